// File: rtl/pool_engine_pkg.sv
// Shared constants and types for the pooling stage.
package pool_engine_pkg;

  localparam int DW_DEF = 20;

  // Layer memory map selects
  localparam logic [2:0] L0_K0 = 3'b001;
  localparam logic [2:0] L0_K1 = 3'b010;
  localparam logic [2:0] L1_K0 = 3'b011;
  localparam logic [2:0] L1_K1 = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_FIN
  } pool_state_t;

  // Counter width that stays legal when the count range collapses to one value
  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/pool_engine_if.sv
// Control handshake and layer memory bus of the pooling stage.
interface pool_engine_if #(
  parameter int DW = 20,
  parameter int AW = 12
);
  logic          start;
  logic          mode;
  logic          busy;
  logic          done;
  logic          crd;
  logic [AW-1:0] caddr_rd;
  logic [DW-1:0] cdata_rd;
  logic          cwr;
  logic [AW-1:0] caddr_wr;
  logic [DW-1:0] cdata_wr;
  logic [2:0]    csel;

  // Engine side
  modport master (
    input  start, mode, cdata_rd,
    output busy, done, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
  );

  // Controller / memory side
  modport slave (
    output start, mode, cdata_rd,
    input  busy, done, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
  );
endinterface

// File: rtl/pool_engine_addr_gen.sv
// Window/sample counters for the pooling pass.
// Counters name the sample being read this cycle; rd_addr is registered
// from the next counter values so it lines up with the read strobe.
module pool_engine_addr_gen
  import pool_engine_pkg::*;
#(
  parameter int W   = 64,
  parameter int P   = 2,
  parameter int CH  = 1,
  parameter int AW  = 12,
  localparam int KW  = clog2_min1(P),
  localparam int OW  = clog2_min1(W / P),
  localparam int CHW = clog2_min1(CH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           step,
  output logic [CHW-1:0] ch,
  output logic [AW-1:0]  rd_addr,
  output logic [AW-1:0]  wr_addr,
  output logic           first_k,
  output logic           last_k,
  output logic           last_win
);

  logic [KW-1:0]  kx, ky, n_kx, n_ky;
  logic [OW-1:0]  ox, oy, n_ox, n_oy;
  logic [CHW-1:0] n_ch;

  wire kx_end = (kx == KW'(P - 1));
  wire ky_end = (ky == KW'(P - 1));
  wire ox_end = (ox == OW'(W / P - 1));
  wire oy_end = (oy == OW'(W / P - 1));
  wire ch_end = (ch == CHW'(CH - 1));

  assign first_k  = (kx == '0) && (ky == '0);
  assign last_k   = kx_end && ky_end;
  assign last_win = ox_end && oy_end && ch_end;
  assign wr_addr  = AW'(int'(oy) * (W / P) + int'(ox));

  // Next sample: kx fastest, then ky, ox, oy, channel; wraps to zero after the pass
  always_comb begin
    n_kx = kx;
    n_ky = ky;
    n_ox = ox;
    n_oy = oy;
    n_ch = ch;
    if (step) begin
      if (!kx_end) n_kx = kx + KW'(1);
      else begin
        n_kx = '0;
        if (!ky_end) n_ky = ky + KW'(1);
        else begin
          n_ky = '0;
          if (!ox_end) n_ox = ox + OW'(1);
          else begin
            n_ox = '0;
            if (!oy_end) n_oy = oy + OW'(1);
            else begin
              n_oy = '0;
              n_ch = ch_end ? '0 : ch + CHW'(1);
            end
          end
        end
      end
    end
  end

  // Counter state and registered read address
  always_ff @(posedge clk) begin
    if (reset) begin
      kx      <= '0;
      ky      <= '0;
      ox      <= '0;
      oy      <= '0;
      ch      <= '0;
      rd_addr <= '0;
    end else begin
      kx      <= n_kx;
      ky      <= n_ky;
      ox      <= n_ox;
      oy      <= n_oy;
      ch      <= n_ch;
      rd_addr <= AW'((int'(n_oy) * P + int'(n_ky)) * W + int'(n_ox) * P + int'(n_kx));
    end
  end

endmodule

// File: rtl/pool_engine.sv
// PxP pooling engine: reads each window from the source map, reduces it
// (max, or rounded average when built with POOL_AVG_EN) and writes one pixel
// to the destination map. Without POOL_AVG_EN, mode is ignored.
module pool_engine
  import pool_engine_pkg::*;
#(
  parameter int         DW       = DW_DEF,
  parameter int         W        = 64,
  parameter int         P        = 2,
  parameter int         CH       = 1,
  parameter logic [2:0] SRC_SEL0 = L0_K0,
  parameter logic [2:0] DST_SEL0 = L1_K0,
  parameter int         AW       = 12
) (
  input logic           clk,
  input logic           reset,
  pool_engine_if.master bus
);

  localparam int CHW = clog2_min1(CH);
`ifdef POOL_AVG_EN
  localparam int S    = 2 * $clog2(P);
  localparam int ACCW = DW + S;
  localparam int RW   = ACCW + 1;
`else
  localparam int ACCW = DW;
`endif

  pool_state_t    state;
  logic [CHW-1:0] ch;
  logic [AW-1:0]  rd_addr, wr_addr;
  logic           first_k, last_k, last_win, last_q;
  logic [ACCW-1:0] acc, acc_nxt, sample;
  logic [DW-1:0]  res;
  logic           busy_q, done_q, crd_q, cwr_q;
  logic [AW-1:0]  caddr_wr_q;
  logic [DW-1:0]  cdata_wr_q;
  logic [2:0]     csel_q;

  pool_engine_addr_gen #(.W(W), .P(P), .CH(CH), .AW(AW)) u_addr (
    .clk      (clk),
    .reset    (reset),
    .step     (state == ST_READ),
    .ch       (ch),
    .rd_addr  (rd_addr),
    .wr_addr  (wr_addr),
    .first_k  (first_k),
    .last_k   (last_k),
    .last_win (last_win)
  );

  wire [2:0] src_sel = SRC_SEL0 + 3'(ch);
  wire [2:0] dst_sel = DST_SEL0 + 3'(ch);

  assign sample = ACCW'(bus.cdata_rd);

`ifdef POOL_AVG_EN
  logic          mode_q;
  logic [RW-1:0] rnd;

  // Window reduction; first sample of a window reloads the accumulator
  always_comb begin
    acc_nxt = (!first_k && acc > sample) ? acc : sample;
    if (mode_q) acc_nxt = first_k ? sample : acc + sample;
  end

  // Round half up, then clamp to the pixel range
  always_comb begin
    rnd = ({1'b0, acc_nxt} + RW'(1 << (S - 1))) >> S;
    res = acc_nxt[DW-1:0];
    if (mode_q) res = (rnd > RW'({DW{1'b1}})) ? {DW{1'b1}} : rnd[DW-1:0];
  end
`else
  logic unused_mode;
  assign unused_mode = bus.mode;

  // Window max; first sample of a window reloads the accumulator
  always_comb begin
    acc_nxt = (!first_k && acc > sample) ? acc : sample;
    res     = acc_nxt;
  end
`endif

  // Pass sequencing with registered bus outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      crd_q      <= 1'b0;
      cwr_q      <= 1'b0;
      csel_q     <= '0;
      caddr_wr_q <= '0;
      cdata_wr_q <= '0;
      acc        <= '0;
      last_q     <= 1'b0;
`ifdef POOL_AVG_EN
      mode_q     <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state  <= ST_READ;
            busy_q <= 1'b1;
            crd_q  <= 1'b1;
            csel_q <= src_sel;
`ifdef POOL_AVG_EN
            mode_q <= bus.mode;
`endif
          end
        end
        ST_READ: begin
          acc <= acc_nxt;
          if (last_k) begin
            state      <= ST_WRITE;
            crd_q      <= 1'b0;
            cwr_q      <= 1'b1;
            caddr_wr_q <= wr_addr;
            cdata_wr_q <= res;
            csel_q     <= dst_sel;
            last_q     <= last_win;
          end
        end
        ST_WRITE: begin
          cwr_q <= 1'b0;
          if (last_q) begin
            state  <= ST_FIN;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            csel_q <= '0;
          end else begin
            state  <= ST_READ;
            crd_q  <= 1'b1;
            csel_q <= src_sel;
          end
        end
        ST_FIN: begin
          done_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.crd      = crd_q;
  assign bus.caddr_rd = rd_addr;
  assign bus.cwr      = cwr_q;
  assign bus.caddr_wr = caddr_wr_q;
  assign bus.cdata_wr = cdata_wr_q;
  assign bus.csel     = csel_q;

endmodule

// File: tb/tb_pool_engine.sv
// Bench for pool_engine: W=16, P=2, CH=2 against a window-level reference model.
// Define POOL_AVG_EN for both bench and RTL to exercise average mode.
module tb_pool_engine;
  import pool_engine_pkg::*;

  localparam int DW   = 20;
  localparam int W    = 16;
  localparam int P    = 2;
  localparam int CH   = 2;
  localparam int AW   = 8;
  localparam int OWN  = W / P;
  localparam int NWIN = CH * OWN * OWN;
  localparam int BUSY_EXP = NWIN * (P * P + 1);
  localparam int LIMIT    = BUSY_EXP + 64;
  localparam logic [2:0] SRC0 = L0_K0;
  localparam logic [2:0] DST0 = L1_K0;
`ifdef POOL_AVG_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pool_engine_if #(.DW(DW), .AW(AW)) bus ();

  pool_engine #(.DW(DW), .W(W), .P(P), .CH(CH), .SRC_SEL0(SRC0), .DST_SEL0(DST0), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DW-1:0] mem [8][W*W];
  assign bus.cdata_rd = mem[bus.csel][bus.caddr_rd];

  typedef struct packed {
    logic [2:0]    sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t wq[$];
  int  busy_cnt, done_cnt, both_cnt;
  int  vec, err;

  // Bus monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.busy) busy_cnt++;
    if (bus.done) done_cnt++;
    if (bus.crd && bus.cwr) both_cnt++;
    if (bus.cwr) wq.push_back('{bus.csel, bus.caddr_wr, bus.cdata_wr});
  end

  // Expected pooled pixel for one window, straight from the source map
  function automatic logic [DW-1:0] ref_pool(input int c, input int oy, input int ox, input bit avg);
    longint sum = 0, mx = 0, v, r;
    for (int ky = 0; ky < P; ky++)
      for (int kx = 0; kx < P; kx++) begin
        v = longint'(mem[3'(int'(SRC0) + c)][AW'((oy * P + ky) * W + ox * P + kx)]);
        sum += v;
        if (v > mx) mx = v;
      end
    if (avg) begin
      r = (sum + (P * P) / 2) / (P * P);
      if (r > (64'd1 << DW) - 1) r = (64'd1 << DW) - 1;
      return DW'(r);
    end
    return DW'(mx);
  endfunction

  task automatic fill(input int c, input int kind, input logic [DW-1:0] k);
    for (int a = 0; a < W * W; a++)
      case (kind)
        0: mem[3'(int'(SRC0) + c)][a] = DW'(a);
        1: mem[3'(int'(SRC0) + c)][a] = k;
        default: mem[3'(int'(SRC0) + c)][a] = DW'($urandom);
      endcase
  endtask

  task automatic clear_mon();
    busy_cnt = 0;
    done_cnt = 0;
    both_cnt = 0;
    wq.delete();
  endtask

  // One full pass; mode wiggles after start to prove it is latched
  task automatic run_pass(input string tag, input bit mode, input bit poke);
    bit avg;
    avg = mode & AVG;
    @(negedge clk);
    clear_mon();
    bus.mode  = mode;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int n = 0; n < LIMIT && done_cnt == 0; n++) begin
      @(negedge clk);
      bus.mode  = 1'($urandom);
      bus.start = (poke && (n == 37 || n == 300)) ? 1'b1 : 1'b0;
    end
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    vec++;
    if (done_cnt != 1) begin
      err++;
      $display("FAIL %s done_pulses: got %0d want 1", tag, done_cnt);
    end
    vec++;
    if (busy_cnt != BUSY_EXP) begin
      err++;
      $display("FAIL %s busy_cycles: got %0d want %0d", tag, busy_cnt, BUSY_EXP);
    end
    vec++;
    if (both_cnt != 0) begin
      err++;
      $display("FAIL %s crd_and_cwr: got %0d cycles want 0", tag, both_cnt);
    end
    vec++;
    if (wq.size() != NWIN) begin
      err++;
      $display("FAIL %s write_count: got %0d want %0d", tag, wq.size(), NWIN);
    end
    for (int i = 0; i < NWIN && i < wq.size(); i++) begin
      int  c, w;
      wr_t e;
      c = i / (OWN * OWN);
      w = i % (OWN * OWN);
      e = '{3'(int'(DST0) + c), AW'(w), ref_pool(c, w / OWN, w % OWN, avg)};
      vec++;
      if (wq[i] !== e) begin
        err++;
        $display("FAIL %s write[%0d]: got sel=%0d addr=%0d data=%h want sel=%0d addr=%0d data=%h",
                 tag, i, wq[i].sel, wq[i].addr, wq[i].data, e.sel, e.addr, e.data);
      end
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    repeat (3) @(negedge clk);
    vec++;
    if ({bus.busy, bus.done, bus.crd, bus.cwr} !== 4'b0) begin
      err++;
      $display("FAIL reset_strobes: got busy/done/crd/cwr=%b want 0000",
               {bus.busy, bus.done, bus.crd, bus.cwr});
    end
    vec++;
    if ({bus.csel, bus.caddr_rd, bus.caddr_wr, bus.cdata_wr} !== '0) begin
      err++;
      $display("FAIL reset_bus: got csel=%0d ard=%0d awr=%0d dwr=%h want all 0",
               bus.csel, bus.caddr_rd, bus.caddr_wr, bus.cdata_wr);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ramp();
    logic [DW-1:0] e0, e63;
    fill(0, 0, '0);
    fill(1, 1, DW'(7));
    for (int m = 0; m < 2; m++) begin
      run_pass(m ? "ramp_mode1" : "ramp_mode0", 1'(m), 1'b0);
      e0  = (m == 1 && AVG) ? DW'(9)   : DW'(17);
      e63 = (m == 1 && AVG) ? DW'(247) : DW'(255);
      vec++;
      if (wq.size() != NWIN || wq[0].data !== e0 || wq[63].data !== e63 || wq[64].sel !== 3'b100) begin
        err++;
        $display("FAIL ramp_directed m%0d: got first/last ch0 outputs %h/%h want %h/%h",
                 m, (wq.size() > 0) ? wq[0].data : '0, (wq.size() > 63) ? wq[63].data : '0, e0, e63);
      end
    end
  endtask

  task automatic test_saturate();
    fill(0, 1, '1);
    fill(1, 1, '1);
    run_pass("sat_mode1", 1'b1, 1'b0);
    run_pass("sat_mode0", 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      fill(0, 2, '0);
      fill(1, 2, '0);
      run_pass("random", 1'($urandom), 1'b0);
    end
  endtask

  task automatic test_start_while_busy();
    fill(0, 2, '0);
    fill(1, 2, '0);
    run_pass("start_busy", 1'($urandom), 1'b1);
  endtask

  task automatic test_reset_mid();
    int sz, n;
    fill(0, 2, '0);
    fill(1, 2, '0);
    @(negedge clk);
    clear_mon();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (n = 0; n < LIMIT && wq.size() < 100; n++) @(negedge clk);
    vec++;
    if (wq.size() < 100) begin
      err++;
      $display("FAIL midreset_reach: got %0d writes want 100", wq.size());
    end
    reset = 1'b1;
    @(negedge clk);
    vec++;
    if ({bus.crd, bus.cwr, bus.busy} !== 3'b000) begin
      err++;
      $display("FAIL midreset_quiet: got crd/cwr/busy=%b want 000", {bus.crd, bus.cwr, bus.busy});
    end
    repeat (2) @(negedge clk);
    sz = wq.size();
    reset = 1'b0;
    repeat (12) @(negedge clk);
    vec++;
    if (wq.size() != sz || done_cnt != 0) begin
      err++;
      $display("FAIL midreset_abandon: got %0d extra writes, %0d done want 0/0", wq.size() - sz, done_cnt);
    end
    run_pass("after_reset", 1'($urandom), 1'b0);
  endtask

  task automatic test_back_to_back();
    fill(0, 2, '0);
    fill(1, 0, '0);
    run_pass("b2b_a", 1'b0, 1'b0);
    run_pass("b2b_b", 1'b1, 1'b0);
  endtask

  initial begin
    vec = 0;
    err = 0;
    clear_mon();
    test_reset();
    test_ramp();
    test_saturate();
    test_random();
    test_start_while_busy();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
